// File: rtl/ccff_prog_driver.sv
// ccff_prog_driver: serialises a word-wide bitstream into a ccff configuration chain
//   params : CHAIN_LEN (chain bits), WORD_W (bitstream word width)
//   inputs : prog_clk, pReset_n (sync, active-low), start, cfg_data/cfg_valid, ccff_tail
//   outputs: cfg_ready, ccff_head, prog_clk_en, busy, done
//   macro  : CCFF_READBACK_EN adds a rotate-and-CRC readback pass with readback_ok/readback_err
module ccff_prog_driver #(
  parameter int CHAIN_LEN = 17,
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              busy,
`ifdef CCFF_READBACK_EN
  output logic              done,
  output logic              readback_ok,
  output logic              readback_err
`else
  output logic              done
`endif
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LEN = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] FIRST = CW'(WORD_W < CHAIN_LEN ? WORD_W : CHAIN_LEN);
  localparam logic [CW-1:0] ONE = CW'(1);
`ifdef CCFF_READBACK_EN
  typedef enum logic [1:0] {IDLE, LOAD, RDBK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [CW-1:0] nbuf_q, nbuf_d, bit_q, bit_d, rem;
  logic shift;
  assign shift = state_q == LOAD && nbuf_q != '0;
  assign rem = LEN - bit_q;
  assign cfg_ready = state_q == LOAD && nbuf_q == '0 && bit_q < LEN;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
`ifdef CCFF_READBACK_EN
  logic [15:0] crc_tx_q, crc_tx_d, crc_rx_q, crc_rx_d;
  logic ok_q, ok_d, err_q, err_d;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
  // readback rotates the chain through itself so its contents come back unchanged
  assign prog_clk_en = shift || state_q == RDBK;
  assign ccff_head = state_q == RDBK ? ccff_tail : shift & buf_q[0];
  assign readback_ok = ok_q;
  assign readback_err = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign prog_clk_en = shift;
  assign ccff_head = shift & buf_q[0];
`endif
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    nbuf_d = nbuf_q;
    bit_d = bit_q;
`ifdef CCFF_READBACK_EN
    crc_tx_d = crc_tx_q;
    crc_rx_d = crc_rx_q;
    ok_d = ok_q;
    err_d = err_q;
`endif
    if (state_q == IDLE) begin
      if (start) begin
        state_d = LOAD;
        nbuf_d = '0;
        bit_d = '0;
`ifdef CCFF_READBACK_EN
        crc_tx_d = 16'hFFFF;
        ok_d = 1'b0;
        err_d = 1'b0;
`endif
      end
    end else if (state_q == LOAD) begin
      if (cfg_ready && cfg_valid) begin
        buf_d = cfg_data;
        // the final word only contributes the bits the chain still needs
        nbuf_d = rem < FIRST ? rem : FIRST;
      end else if (shift) begin
        buf_d = buf_q >> 1;
        nbuf_d = nbuf_q - ONE;
        bit_d = bit_q + ONE;
`ifdef CCFF_READBACK_EN
        crc_tx_d = crc_step(crc_tx_q, buf_q[0]);
`endif
        if (bit_q == LAST) begin
`ifdef CCFF_READBACK_EN
          state_d = RDBK;
          bit_d = '0;
          crc_rx_d = 16'hFFFF;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef CCFF_READBACK_EN
    end else if (state_q == RDBK) begin
      bit_d = bit_q + ONE;
      crc_rx_d = crc_step(crc_rx_q, ccff_tail);
      if (bit_q == LAST) begin
        state_d = DONE;
        ok_d = crc_rx_d == crc_tx_q;
        err_d = crc_rx_d != crc_tx_q;
      end
`endif
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state_q <= IDLE;
      buf_q <= '0;
      nbuf_q <= '0;
      bit_q <= '0;
`ifdef CCFF_READBACK_EN
      crc_tx_q <= '0;
      crc_rx_q <= '0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      nbuf_q <= nbuf_d;
      bit_q <= bit_d;
`ifdef CCFF_READBACK_EN
      crc_tx_q <= crc_tx_d;
      crc_rx_q <= crc_rx_d;
      ok_q <= ok_d;
      err_q <= err_d;
`endif
    end
  end
endmodule
